// File: rtl/simon_decrypt_core_if.sv
// Request/result bundle for the Simon32/64 decrypt core: key and ciphertext in, plaintext out.
// Requester drives start/key/ct_in; the core answers with busy, a done pulse and pt_out.
interface simon_decrypt_core_if #(
    parameter int N = 16
);
    logic             start;
    logic [4*N-1:0]   key;
    logic [2*N-1:0]   ct_in;
    logic             busy;
    logic             done;
    logic [2*N-1:0]   pt_out;

    modport master (output start, key, ct_in, input  busy, done, pt_out);
    modport slave  (input  start, key, ct_in, output busy, done, pt_out);
endinterface

// File: rtl/simon_decrypt_core.sv
// Iterative Simon32/64 decryptor: 28-step key expansion then 32 inverse rounds, done 60 edges after start.
// No backpressure: start is sampled only in IDLE and ignored while busy; pt_out holds until the next done.
module simon_decrypt_core #(
    parameter int N      = 16,
    parameter int ROUNDS = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    simon_decrypt_core_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, KEYEXP, DEC} state_t;

    localparam logic [N-1:0] C          = {{(N-2){1'b1}}, 2'b00};
    localparam logic [31:0]  Z0         = 32'b11111010001001010110000111001101;
    localparam logic [4:0]   KEXP_LAST  = 5'(ROUNDS - 5);
    localparam logic [4:0]   ROUND_LAST = 5'(ROUNDS - 1);

    state_t         state_q;
    logic [4:0]     rc_q;
    logic [N-1:0]   w0_q, w1_q, w2_q, w3_q;
    logic [N-1:0]   l_q, r_q;
    logic           busy_q, done_q;
    logic [2*N-1:0] pt_q;

    logic [N-1:0]   tmp_fwd, tmp_bwd;
    logic [N-1:0]   k_next_d, k_prev_d;
    logic [N-1:0]   l_d, r_d;
    logic [4:0]     zb_idx;

    function automatic logic [N-1:0] rotl(input logic [N-1:0] x, input int s);
        return (x << s) | (x >> (N - s));
    endfunction

    function automatic logic [N-1:0] rotr(input logic [N-1:0] x, input int s);
        return (x >> s) | (x << (N - s));
    endfunction

    function automatic logic [N-1:0] f_fn(input logic [N-1:0] x);
        return (rotl(x, 1) & rotl(x, 8)) ^ rotl(x, 2);
    endfunction

    // z0 is stored MSB-first so sequence bit i lives at Z0[31-i].
    function automatic logic [N-1:0] zterm(input logic [4:0] idx);
        return {{(N-1){1'b0}}, Z0[5'd31 - idx]};
    endfunction

    always_comb begin
        tmp_fwd  = rotr(w3_q, 3) ^ w1_q;
        k_next_d = w0_q ^ C ^ zterm(rc_q) ^ tmp_fwd ^ rotr(tmp_fwd, 1);
        // Regenerate k[rc-4] from the window so the schedule can run backwards without storage.
        zb_idx   = rc_q - 5'd4;
        tmp_bwd  = rotr(w2_q, 3) ^ w0_q;
        k_prev_d = w3_q ^ C ^ zterm(zb_idx) ^ tmp_bwd ^ rotr(tmp_bwd, 1);
        l_d      = r_q;
        r_d      = l_q ^ f_fn(r_q) ^ w3_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rc_q    <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
            w3_q    <= '0;
            l_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        w0_q    <= bus.key[N-1:0];
                        w1_q    <= bus.key[2*N-1:N];
                        w2_q    <= bus.key[3*N-1:2*N];
                        w3_q    <= bus.key[4*N-1:3*N];
                        l_q     <= bus.ct_in[2*N-1:N];
                        r_q     <= bus.ct_in[N-1:0];
                        rc_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= KEYEXP;
                    end
                end
                KEYEXP: begin
                    w0_q <= w1_q;
                    w1_q <= w2_q;
                    w2_q <= w3_q;
                    w3_q <= k_next_d;
                    if (rc_q == KEXP_LAST) begin
                        rc_q    <= ROUND_LAST;
                        state_q <= DEC;
                    end else begin
                        rc_q <= rc_q + 5'd1;
                    end
                end
                DEC: begin
                    l_q  <= l_d;
                    r_q  <= r_d;
                    w0_q <= k_prev_d;
                    w1_q <= w0_q;
                    w2_q <= w1_q;
                    w3_q <= w2_q;
                    rc_q <= rc_q - 5'd1;
                    if (rc_q == 5'd0) begin
                        pt_q    <= {l_d, r_d};
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.pt_out = pt_q;
endmodule

// File: tb/tb_simon_decrypt_core.sv
// Directed and round-trip bench for simon_decrypt_core; expectations come from literals and a forward Simon32/64 encryptor.
module tb_simon_decrypt_core;
    localparam logic [63:0] KNOWN_KEY = 64'h1918111009080100;
    localparam logic [31:0] KNOWN_CT  = 32'hC69BE9BB;
    localparam logic [31:0] KNOWN_PT  = 32'h65656877;
    localparam bit   [31:0] ZSEQ      = 32'b11111010001001010110000111001101;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   overlap = 0;
    logic [31:0] last_pt = '0;

    simon_decrypt_core_if #(.N(16)) bus ();

    simon_decrypt_core #(.N(16), .ROUNDS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (bus.busy && bus.done) overlap++;

    typedef struct {
        logic [63:0] key;
        logic [31:0] ct;
        logic [31:0] pt;
    } vec_t;

    function automatic logic [15:0] ror16(input logic [15:0] x, input int s);
        return (x >> s) | (x << (16 - s));
    endfunction

    function automatic logic [15:0] rol16(input logic [15:0] x, input int s);
        return (x << s) | (x >> (16 - s));
    endfunction

    function automatic logic [31:0] simon_enc(input logic [63:0] k, input logic [31:0] pt);
        logic [15:0] ks [32];
        logic [15:0] tmp, x, y, t;
        for (int i = 0; i < 4; i++) ks[i] = k[16*i +: 16];
        for (int i = 4; i < 32; i++) begin
            tmp   = ror16(ks[i-1], 3) ^ ks[i-3];
            tmp   = tmp ^ ror16(tmp, 1);
            ks[i] = ~ks[i-4] ^ tmp ^ {15'd0, ZSEQ[31-(i-4)]} ^ 16'd3;
        end
        x = pt[31:16];
        y = pt[15:0];
        for (int i = 0; i < 32; i++) begin
            t = x;
            x = y ^ ((rol16(x, 1) & rol16(x, 8)) ^ rol16(x, 2)) ^ ks[i];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // One full operation; optionally re-pulses start (with junk key/ct) at edge poke_at after the start edge.
    task automatic run_op(input logic [63:0] k, input logic [31:0] ct, input logic [31:0] exp_pt,
                          input string nm, input int poke_at);
        int lat = 0;
        int nbusy = 0;
        logic [31:0] held = last_pt;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = k;
        bus.ct_in = ct;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.key   = {$urandom, $urandom};
        bus.ct_in = $urandom;
        if (bus.busy) nbusy++;
        if (bus.pt_out !== last_pt) held = bus.pt_out;
        for (int n = 1; n <= 200 && lat == 0; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) lat = n;
            else begin
                if (bus.busy) nbusy++;
                if (bus.pt_out !== last_pt) held = bus.pt_out;
            end
            bus.start = (poke_at != 0 && n == poke_at - 1);
            if (bus.start) begin
                bus.key   = {$urandom, $urandom};
                bus.ct_in = $urandom;
            end
        end
        bus.start = 1'b0;
        check({nm, " latency"}, 64'(lat), 64'd60);
        check({nm, " pt_out"}, 64'(bus.pt_out), 64'(exp_pt));
        check({nm, " busy cycles"}, 64'(nbusy), 64'd60);
        check({nm, " pt_out held"}, 64'(held), 64'(last_pt));
        last_pt = exp_pt;
    endtask

    vec_t tbl [6];

    initial begin
        int dcount;
        int dpos [3];
        logic [31:0] dpt [3];
        logic [63:0] rk;
        logic [31:0] rp;

        tbl[0] = '{KNOWN_KEY, KNOWN_CT, KNOWN_PT};
        tbl[1] = '{64'h0, 32'h0, 32'h0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'hFFFF_FFFF};
        tbl[3] = '{64'h0123_4567_89AB_CDEF, 32'h0, 32'hDEAD_BEEF};
        tbl[4] = '{64'h8000_0000_0000_0001, 32'h0, 32'h0001_8000};
        tbl[5] = '{64'hA5A5_5A5A_0F0F_F0F0, 32'h0, 32'h1234_5678};
        for (int i = 1; i < 6; i++) tbl[i].ct = simon_enc(tbl[i].key, tbl[i].pt);

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.key   = '0;
        bus.ct_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset pt_out", 64'(bus.pt_out), 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run_op(tbl[i].key, tbl[i].ct, tbl[i].pt, $sformatf("vec%0d", i), 0);

        run_op(KNOWN_KEY, KNOWN_CT, KNOWN_PT, "start ignored while busy", 30);

        // Start held high: a new op is accepted in every done cycle.
        dcount = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = KNOWN_KEY;
        bus.ct_in = KNOWN_CT;
        for (int e = 1; e <= 190; e++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                if (dcount < 3) begin
                    dpos[dcount] = e;
                    dpt[dcount]  = bus.pt_out;
                end
                dcount++;
            end
        end
        bus.start = 1'b0;
        check("b2b done count", 64'(dcount), 64'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b done%0d edge", i), 64'(dpos[i]), 64'(61 + 61 * i));
            check($sformatf("b2b done%0d pt", i), 64'(dpt[i]), 64'(KNOWN_PT));
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        last_pt = '0;

        run_op(KNOWN_KEY, KNOWN_CT, KNOWN_PT, "prime before abort", 0);

        // Abort: reset sampled at edge +45 after the start edge.
        @(negedge clk);
        bus.start = 1'b1;
        bus.key   = KNOWN_KEY;
        bus.ct_in = KNOWN_CT;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (44) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", 64'(bus.busy), 64'd0);
        check("abort done", 64'(bus.done), 64'd0);
        check("abort pt_out", 64'(bus.pt_out), 64'd0);
        dcount = 0;
        repeat (100) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) dcount++;
        end
        check("abort no done", 64'(dcount), 64'd0);
        last_pt = '0;
        run_op(KNOWN_KEY, KNOWN_CT, KNOWN_PT, "after abort", 0);

        for (int i = 0; i < 1000; i++) begin
            rk = {$urandom, $urandom};
            rp = $urandom;
            run_op(rk, simon_enc(rk, rp), rp, $sformatf("rt%0d", i), 0);
        end

        check("busy/done overlap", 64'(overlap), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
